// File: rtl/network_pkg.sv
// network_pkg: widths, fixed weights/biases and FSM state type shared by
// the two-layer fixed-point network (top: network, sub: network_neuron).
package network_pkg;

    localparam int IN_W   = 33;
    localparam int OUT_W  = 34;
    localparam int WGT_W  = 8;
    localparam int ACC_W  = 48;
    localparam int PROD_W = IN_W + WGT_W;
    localparam int N_IN   = 9;
    localparam int N_HID  = 3;

    localparam logic signed [WGT_W-1:0] W1 [N_HID][N_IN] = '{
        '{8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1},
        '{-8'sd1, -8'sd1, -8'sd1, -8'sd1, -8'sd1, -8'sd1, -8'sd1, -8'sd1, -8'sd1},
        '{8'sd0, 8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5, 8'sd6, 8'sd7, 8'sd8}
    };
    localparam logic signed [ACC_W-1:0] B1 [N_HID] = '{48'sd0, 48'sd0, 48'sd0};
    localparam logic signed [WGT_W-1:0] W2 [N_HID] = '{8'sd1, 8'sd1, 8'sd1};
    localparam logic signed [ACC_W-1:0] B2 = 48'sd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_L1   = 2'd1,
        S_L2   = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/network_neuron.sv
// network_neuron: serial multiply-accumulate neuron. clr_i zeroes the
// accumulator, acc_i adds x_i*w_i, fin_i (together with the last acc_i)
// registers bias + optional ReLU + saturation of the completed sum.
module network_neuron
    import network_pkg::*;
#(
    parameter int                       SAT_W   = IN_W,
    parameter bit                       RELU_EN = 1'b0,
    parameter logic signed [ACC_W-1:0]  BIAS    = {ACC_W{1'b0}}
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_i,
    input  logic                    acc_i,
    input  logic                    fin_i,
    input  logic signed [IN_W-1:0]  x_i,
    input  logic signed [WGT_W-1:0] w_i,
    output logic signed [SAT_W-1:0] y_o
);

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        $signed({{(ACC_W-SAT_W+1){1'b0}}, {(SAT_W-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        $signed({{(ACC_W-SAT_W+1){1'b1}}, {(SAT_W-1){1'b0}}});

    logic signed [PROD_W-1:0] x_ext_s;
    logic signed [PROD_W-1:0] w_ext_s;
    logic signed [PROD_W-1:0] prod_s;
    logic signed [ACC_W-1:0]  sum_s;
    logic signed [ACC_W-1:0]  biased_s;
    logic signed [ACC_W-1:0]  act_s;
    logic signed [SAT_W-1:0]  sat_s;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [SAT_W-1:0]  y_q;

    // Product and running sum including the current term, so finalize can
    // coincide with the last accumulate.
    always_comb begin
        x_ext_s  = {{(PROD_W-IN_W){x_i[IN_W-1]}}, x_i};
        w_ext_s  = {{(PROD_W-WGT_W){w_i[WGT_W-1]}}, w_i};
        prod_s   = x_ext_s * w_ext_s;
        sum_s    = acc_q + {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
        biased_s = sum_s + BIAS;
    end

    // Activation then clamp to the signed SAT_W range.
    always_comb begin
        if (RELU_EN && biased_s[ACC_W-1]) begin
            act_s = {ACC_W{1'b0}};
        end else begin
            act_s = biased_s;
        end
        if (act_s > SAT_MAX) begin
            sat_s = SAT_MAX[SAT_W-1:0];
        end else if (act_s < SAT_MIN) begin
            sat_s = SAT_MIN[SAT_W-1:0];
        end else begin
            sat_s = act_s[SAT_W-1:0];
        end
    end

    // Accumulator register: clear on new vector, add on each MAC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= {ACC_W{1'b0}};
        end else if (clr_i) begin
            acc_q <= {ACC_W{1'b0}};
        end else if (acc_i) begin
            acc_q <= sum_s;
        end else begin
            acc_q <= acc_q;
        end
    end

    // Neuron output register, loaded once per vector on the final MAC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= {SAT_W{1'b0}};
        end else if (acc_i && fin_i) begin
            y_q <= sat_s;
        end else begin
            y_q <= y_q;
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/network.sv
// network: fixed-weight 9-3-1 fixed-point inference engine. One start in
// IDLE captures a vector; 9 L1 cycles, 3 L2 cycles and one DONE cycle later
// out_2 updates with a one-cycle end_2 strobe.
// Build option: define NETWORK_RELU_EN for ReLU on the hidden layer.
module network
    import network_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic signed [IN_W-1:0]  input_0,
    input  logic signed [IN_W-1:0]  input_1,
    input  logic signed [IN_W-1:0]  input_2,
    input  logic signed [IN_W-1:0]  input_3,
    input  logic signed [IN_W-1:0]  input_4,
    input  logic signed [IN_W-1:0]  input_5,
    input  logic signed [IN_W-1:0]  input_6,
    input  logic signed [IN_W-1:0]  input_7,
    input  logic signed [IN_W-1:0]  input_8,
    output logic signed [OUT_W-1:0] out_2,
    output logic                    end_2
);

`ifdef NETWORK_RELU_EN
    localparam bit HID_RELU = 1'b1;
`else
    localparam bit HID_RELU = 1'b0;
`endif

    state_t                   state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic signed [IN_W-1:0]   x_in_s [N_IN];
    logic signed [IN_W-1:0]   x_q    [N_IN];
    logic signed [IN_W-1:0]   x_sel_s;
    logic signed [IN_W-1:0]   hid_s  [N_HID];
    logic signed [IN_W-1:0]   h_sel_s;
    logic signed [WGT_W-1:0]  w2_sel_s;
    logic signed [OUT_W-1:0]  y_out_s;
    logic                     clr_s, l1_acc_s, l1_fin_s, l2_acc_s, l2_fin_s;
    logic signed [OUT_W-1:0]  out_2_q;
    logic                     end_2_q;

    assign x_in_s = '{input_0, input_1, input_2, input_3, input_4,
                      input_5, input_6, input_7, input_8};

    // Next-state, index counter and MAC control decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_s    = 1'b0;
        l1_acc_s = 1'b0;
        l1_fin_s = 1'b0;
        l2_acc_s = 1'b0;
        l2_fin_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_L1;
                    cnt_d   = 4'd0;
                    clr_s   = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_L1: begin
                l1_acc_s = 1'b1;
                if (cnt_q == 4'(N_IN - 1)) begin
                    l1_fin_s = 1'b1;
                    cnt_d    = 4'd0;
                    state_d  = S_L2;
                end else begin
                    cnt_d    = cnt_q + 4'd1;
                end
            end
            S_L2: begin
                l2_acc_s = 1'b1;
                if (cnt_q == 4'(N_HID - 1)) begin
                    l2_fin_s = 1'b1;
                    cnt_d    = 4'd0;
                    state_d  = S_DONE;
                end else begin
                    cnt_d    = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State and index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Input vector capture on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_IN; i++) x_q[i] <= {IN_W{1'b0}};
        end else if (clr_s) begin
            for (int i = 0; i < N_IN; i++) x_q[i] <= x_in_s[i];
        end else begin
            for (int i = 0; i < N_IN; i++) x_q[i] <= x_q[i];
        end
    end

    // Operand selection for both layers from the shared index.
    always_comb begin
        x_sel_s = x_q[cnt_q];
        case (cnt_q)
            4'd0: begin h_sel_s = hid_s[0]; w2_sel_s = W2[0]; end
            4'd1: begin h_sel_s = hid_s[1]; w2_sel_s = W2[1]; end
            4'd2: begin h_sel_s = hid_s[2]; w2_sel_s = W2[2]; end
            default: begin h_sel_s = {IN_W{1'b0}}; w2_sel_s = {WGT_W{1'b0}}; end
        endcase
    end

    for (genvar g = 0; g < N_HID; g++) begin : g_hid
        network_neuron #(
            .SAT_W  (IN_W),
            .RELU_EN(HID_RELU),
            .BIAS   (B1[g])
        ) u_hid (
            .clk  (clk),
            .rst_n(rst_n),
            .clr_i(clr_s),
            .acc_i(l1_acc_s),
            .fin_i(l1_fin_s),
            .x_i  (x_sel_s),
            .w_i  (W1[g][cnt_q]),
            .y_o  (hid_s[g])
        );
    end

    network_neuron #(
        .SAT_W  (OUT_W),
        .RELU_EN(1'b0),
        .BIAS   (B2)
    ) u_out (
        .clk  (clk),
        .rst_n(rst_n),
        .clr_i(clr_s),
        .acc_i(l2_acc_s),
        .fin_i(l2_fin_s),
        .x_i  (h_sel_s),
        .w_i  (w2_sel_s),
        .y_o  (y_out_s)
    );

    // Result register and completion strobe, updated on leaving DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_2_q <= {OUT_W{1'b0}};
            end_2_q <= 1'b0;
        end else if (state_q == S_DONE) begin
            out_2_q <= y_out_s;
            end_2_q <= 1'b1;
        end else begin
            out_2_q <= out_2_q;
            end_2_q <= 1'b0;
        end
    end

    assign out_2 = out_2_q;
    assign end_2 = end_2_q;

endmodule

// File: tb/tb_network.sv
// tb_network: randomized self-checking bench for network against an
// arithmetic reference model of the 9-3-1 network.
module tb_network;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [32:0] vec [9];
    logic [33:0] out_2;
    logic        end_2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    network dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .input_0(vec[0]), .input_1(vec[1]), .input_2(vec[2]),
        .input_3(vec[3]), .input_4(vec[4]), .input_5(vec[5]),
        .input_6(vec[6]), .input_7(vec[7]), .input_8(vec[8]),
        .out_2(out_2), .end_2(end_2)
    );

    function automatic longint sat(input longint v, input int w);
        longint mx;
        longint mn;
        mx = (64'sd1 <<< (w - 1)) - 64'sd1;
        mn = -mx - 64'sd1;
        if (v > mx) return mx;
        if (v < mn) return mn;
        return v;
    endfunction

    // Reference: h = act(sat33(sum x_i*W1)), out = sat34(sum h) (W2=1, biases 0).
    function automatic logic [33:0] model();
        longint acc;
        longint hh;
        longint o;
        longint w;
        o = 64'sd0;
        for (int h = 0; h < 3; h++) begin
            acc = 64'sd0;
            for (int i = 0; i < 9; i++) begin
                w = (h == 0) ? 64'sd1 : ((h == 1) ? -64'sd1 : longint'(i));
                acc += longint'($signed(vec[i])) * w;
            end
            hh = sat(acc, 33);
`ifdef NETWORK_RELU_EN
            if (hh < 64'sd0) hh = 64'sd0;
`endif
            o += hh;
        end
        o = sat(o, 34);
        return o[33:0];
    endfunction

    task automatic set_all(input logic [32:0] v);
        for (int i = 0; i < 9; i++) vec[i] = v;
    endtask

    task automatic set_rand();
        for (int i = 0; i < 9; i++) vec[i] = {1'($urandom), 32'($urandom)};
    endtask

    // Pulse start for one edge, then wait (bounded) for end_2; returns latency.
    task automatic launch(output int lat, output logic [33:0] res);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        res = '0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (end_2) begin
                lat = n;
                res = out_2;
                break;
            end
        end
        if (lat < 0) begin
            total++; bad++;
            $display("FAIL launch_timeout: no end_2 within 40 cycles");
        end
    endtask

    task automatic check_vec(input string name);
        int          lat;
        logic [33:0] res;
        logic [33:0] exp;
        exp = model();
        launch(lat, res);
        total++;
        if (lat !== 13) begin
            bad++;
            $display("FAIL %s_latency: got %0d want 13", name, lat);
        end
        total++;
        if (res !== exp) begin
            bad++;
            $display("FAIL %s_value: got %0d want %0d", name, $signed(res), $signed(exp));
        end
        @(posedge clk); #1;
        total++;
        if (end_2 !== 1'b0) begin
            bad++;
            $display("FAIL %s_strobe_width: end_2 got %b want 0", name, end_2);
        end
    endtask

    task automatic test_reset();
        set_all(33'd0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (out_2 !== 34'd0 || end_2 !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: out_2=%0d end_2=%b want 0/0", out_2, end_2);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ones();
        set_all(33'd1);
        check_vec("ones");
    endtask

    task automatic test_zero();
        set_all(33'd0);
        check_vec("zero");
    endtask

    task automatic test_max();
        set_all(33'd4294967295);
        check_vec("max_pos");
        set_all(33'h1_0000_0000);
        check_vec("max_neg");
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            set_rand();
            check_vec("random");
        end
    endtask

    task automatic test_start_ignored();
        logic [33:0] exp;
        int          ends;
        logic [33:0] first;
        set_rand();
        exp = model();
        ends = 0;
        first = '0;
        @(negedge clk);
        start = 1'b1;
        for (int n = 0; n <= 35; n++) begin
            @(posedge clk); #1;
            if (end_2) begin
                if (ends == 0) first = out_2;
                ends++;
            end
            @(negedge clk);
            start = (n == 2 || n == 10) ? 1'b1 : 1'b0;
            if (n == 1) set_rand();
        end
        start = 1'b0;
        total++;
        if (ends !== 1) begin
            bad++;
            $display("FAIL ignore_start_count: end_2 pulses got %0d want 1", ends);
        end
        total++;
        if (first !== exp) begin
            bad++;
            $display("FAIL ignore_start_value: got %0d want %0d", $signed(first), $signed(exp));
        end
    endtask

    task automatic test_reset_mid();
        int ends;
        set_all(33'd1);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_2 !== 34'd0) begin
            bad++;
            $display("FAIL midreset_out: got %0d want 0", out_2);
        end
        ends = 0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk); #1;
            if (end_2) ends++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk); #1;
            if (end_2) ends++;
        end
        total++;
        if (ends !== 0) begin
            bad++;
            $display("FAIL midreset_noend: end_2 pulses got %0d want 0", ends);
        end
        set_rand();
        check_vec("after_reset");
    endtask

    task automatic test_back_to_back();
        logic [33:0] exp;
        int          pulses;
        int          last;
        logic        prev;
        set_all(33'd1);
        exp = model();
        pulses = 0;
        last = -1;
        prev = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (end_2) begin
                pulses++;
                total++;
                if (out_2 !== exp) begin
                    bad++;
                    $display("FAIL b2b_value: got %0d want %0d", $signed(out_2), $signed(exp));
                end
                total++;
                if ((last < 0 && n != 13) || (last >= 0 && n - last != 14)) begin
                    bad++;
                    $display("FAIL b2b_spacing: pulse at %0d previous %0d", n, last);
                end
                total++;
                if (prev) begin
                    bad++;
                    $display("FAIL b2b_double: end_2 high on consecutive cycles at %0d", n);
                end
                last = n;
            end
            prev = end_2;
        end
        @(negedge clk);
        start = 1'b0;
        total++;
        if (pulses !== 2) begin
            bad++;
            $display("FAIL b2b_count: got %0d want 2", pulses);
        end
        repeat (20) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_ones();
        test_zero();
        test_max();
        test_random();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/network.md
# network

Fixed-weight two-layer fixed-point neural network: nine signed inputs feed three hidden neurons (layer 1), whose outputs feed one output neuron (layer 2). A `start` pulse captures one 9-element input vector, the block computes serially with multiply-accumulate units, then presents the signed result on `out_2` with a one-cycle `end_2` strobe. It is the top-level inference engine; the surrounding logic streams input vectors and collects results.

## Interface
- `IN_W`, 33: input sample width (signed).
- `OUT_W`, 34: result width (signed).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request; sampled only in IDLE.
- `input_0` … `input_8`  in  IN_W each  signed input vector elements.
- `out_2`  out  OUT_W  signed network result, held until the next result.
- `end_2`  out  1  one-cycle strobe: `out_2` just updated.

## Operation
- FSM states: IDLE → L1 → L2 → DONE → IDLE.
- IDLE: when `start`=1 at a rising edge, register all nine inputs, clear accumulators, go to L1. Otherwise stay.
- L1, 9 cycles, index i=0..8: each hidden neuron h adds `x_i*W1[h][i]`. Weights are 8-bit signed, products are 41-bit, accumulators are 48-bit signed. On exit, add `B1[h]`, apply activation, and saturate to a signed IN_W value `h_h`.
- L2, 3 cycles, index h=0..2: output accumulator adds `h_h*W2[h]`. On exit, add `B2` and saturate to a signed OUT_W value.
- DONE, 1 cycle: `out_2` gets the saturated sum, `end_2`=1, then return to IDLE.
- Saturation clamps to max positive / min negative of the target width. There is no wrap-around.
- Default constants: `W1[0][i]=1`, `W1[1][i]=-1`, `W1[2][i]=i`, `B1=0`, `W2={1,1,1}`, `B2=0`.
- `start` is ignored in L1, L2 and DONE. Inputs may change freely after capture.

## Timing
- Reset: FSM=IDLE, `out_2`=0, `end_2`=0, accumulators and captured inputs are 0.
- If `start` is sampled at edge k, `end_2` is high in the cycle after edge k+13 and `out_2` changes on that same edge.
- Throughput: at most one result per 14 cycles. A `start` held high continuously launches a new computation on the edge after DONE.
- Reset asserted mid-computation aborts immediately: no `end_2`, and `out_2` returns to 0.
- `end_2` is never high for more than one consecutive cycle.

## Configuration
- `NETWORK_RELU_EN` defined: hidden activation is ReLU, so a negative `h_h` becomes 0.
- `NETWORK_RELU_EN` undefined: hidden activation is identity, so negative values pass through after saturation.
- The output neuron never has an activation.

## Structure
- Package `network_pkg` holds:
  - `IN_W`, `OUT_W`, `WGT_W`=8, `ACC_W`=48
  - `N_IN`=9, `N_HID`=3
  - `W1`, `B1`, `W2`, `B2` constant arrays
  - FSM state typedef
- Sub-module `network_neuron` is a serial MAC with clear, accumulate and finalize controls, bias add, optional ReLU and parameterised output saturation. It is instantiated three times for layer 1 and once for layer 2. The top level contains the FSM, the index counter and input/output registers.

## Test plan
- Reset, then all inputs=1 and `start` pulse → `end_2` at start edge+13 cycles. `out_2`=45 with `NETWORK_RELU_EN` (h=9,0,36) and 36 without it.
- All inputs=0 and `start` → `out_2`=0 with a single `end_2` pulse.
- All inputs=4294967295 → h0 and h2 saturate to 4294967295 and h1 becomes 0 under ReLU → `out_2`=8589934590.
- `start` pulsed again during L1 and L2 → ignored; exactly one `end_2` and the result matches the first vector.
- `rst_n` low in L1 cycle 5 → `out_2`=0, no `end_2`. A new `start` after release yields the correct result.
- `start` held high for 40 cycles with inputs=1 → `end_2` pulses every 14 cycles, each with `out_2`=45 (ReLU enabled).
